// File: rtl/r2mdc_delay_commutator_pkg.sv
// Shared FFT definitions: Q7.8 sample format, complex word, commutator states.
// No logic; constants and types only.
// Imported by every file of the commutator.
package r2mdc_delay_commutator_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int FRAC_BITS = 8;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/r2mdc_delay_commutator_if.sv
// Bundle of the commutator's input stream, output pair stream and status.
// master = upstream/downstream environment, slave = the commutator itself.
// Input is valid/ready; the output side has no backpressure.
interface r2mdc_delay_commutator_if
    import r2mdc_delay_commutator_pkg::*;
#(
    parameter int TW_AW = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic signed [SAMPLE_W-1:0] in0_re;
    logic signed [SAMPLE_W-1:0] in0_im;
    logic signed [SAMPLE_W-1:0] in1_re;
    logic signed [SAMPLE_W-1:0] in1_im;
    logic                       out_valid;
    logic                       out_last;
    logic signed [SAMPLE_W-1:0] a_re;
    logic signed [SAMPLE_W-1:0] a_im;
    logic signed [SAMPLE_W-1:0] b_re;
    logic signed [SAMPLE_W-1:0] b_im;
    logic [TW_AW-1:0]           tw_idx;
    logic                       err_len;

    modport master (
        output in_valid, in_last, in0_re, in0_im, in1_re, in1_im,
        input  in_ready, out_valid, out_last, a_re, a_im, b_re, b_im, tw_idx, err_len
    );

    modport slave (
        input  in_valid, in_last, in0_re, in0_im, in1_re, in1_im,
        output in_ready, out_valid, out_last, a_re, a_im, b_re, b_im, tw_idx, err_len
    );
endinterface

// File: rtl/r2mdc_delay_commutator_cplx_delay_line.sv
// DEPTH-stage shift register of complex words, advancing only when en is high.
// Latency: DEPTH enabled cycles from din to dout.
// No flow control of its own; the caller freezes it by holding en low.
module r2mdc_delay_commutator_cplx_delay_line
    import r2mdc_delay_commutator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  cplx_t din,
    output cplx_t dout
);

    cplx_t taps [DEPTH];

    // Shift one position per enabled cycle; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/r2mdc_delay_commutator.sv
// R2MDC inter-stage delay/commutator: pairs samples DELAY apart and emits twiddle index.
// Latency: pair appears one cycle after the step that completes it (registered outputs).
// in_ready drops for exactly DELAY drain cycles after in_last; outputs are never stalled.
module r2mdc_delay_commutator
    import r2mdc_delay_commutator_pkg::*;
#(
    parameter int DELAY     = 4,
    parameter int TW_STRIDE = 1,
    parameter int TW_AW     = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    r2mdc_delay_commutator_if.slave bus
);

    // k spans one 2*DELAY block, so its top bit tells which half of the block we are in.
    localparam int            CW     = $clog2(DELAY) + 1;
    localparam logic [CW-1:0] K_LAST = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DELAY - 1);
    localparam logic [CW-1:0] K_MASK = CW'(DELAY - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    k;
    logic [CW-1:0]    dcnt;
    logic             ready, draining, primed;
    logic             accept, step, drain_done, sel;
    cplx_t            u_in, l_in, l_dly, u_sel, b_sel, a_dly;
    cplx_t            a_q, b_q;
    logic             out_valid_q, out_last_q, err_q;
    logic [TW_AW-1:0] tw_q, tw_next;

    assign accept     = bus.in_valid & ready;
    assign step       = accept | draining;
    assign drain_done = draining & (dcnt == D_LAST);
    assign sel        = k[CW-1];
    assign tw_next    = TW_AW'(k & K_MASK) * TW_AW'(TW_STRIDE);

    // Drain flushes the lines with zeros; otherwise take the upstream pair.
    always_comb begin
        u_in = '0;
        l_in = '0;
        if (!draining) begin
            u_in.re = bus.in0_re;
            u_in.im = bus.in0_im;
            l_in.re = bus.in1_re;
            l_in.im = bus.in1_im;
        end
    end

    // Commutator switch: first half of a block sends u up and delayed l down, second half swaps.
    always_comb begin
        u_sel = sel ? l_dly : u_in;
        b_sel = sel ? u_in  : l_dly;
    end

    r2mdc_delay_commutator_cplx_delay_line #(.DEPTH(DELAY)) u_lower_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (step),
        .din  (l_in),
        .dout (l_dly)
    );

    r2mdc_delay_commutator_cplx_delay_line #(.DEPTH(DELAY)) u_upper_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (step),
        .din  (u_sel),
        .dout (a_dly)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Next state: prime after DELAY accepts, drain on in_last (even a misplaced one).
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && bus.in_last)    state_nxt = DRAIN;
                else if (accept && k == D_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (accept && bus.in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (dcnt == D_LAST) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        ready    = (state != DRAIN);
        draining = (state == DRAIN);
        primed   = (state == RUN);
    end

    // Block position and drain progress; both restart at zero when the drain completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= '0;
            dcnt <= '0;
        end else if (step) begin
            k    <= drain_done ? '0 : k + CW'(1);
            dcnt <= drain_done ? '0 : (draining ? dcnt + CW'(1) : dcnt);
        end
    end

    // Sticky length error: in_last must land on the last slot of a 2*DELAY block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                err_q <= 1'b0;
        else if (accept && bus.in_last && k != K_LAST) err_q <= 1'b1;
    end

    // Output pair register; data and index hold between steps, valid/last pulse per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            tw_q        <= '0;
        end else begin
            out_valid_q <= step & (primed | draining);
            out_last_q  <= drain_done;
            if (step) begin
                a_q  <= a_dly;
                b_q  <= b_sel;
                tw_q <= tw_next;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.a_re      = a_q.re;
    assign bus.a_im      = a_q.im;
    assign bus.b_re      = b_q.re;
    assign bus.b_im      = b_q.im;
    assign bus.tw_idx    = tw_q;
    assign bus.err_len   = err_q;

endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// Bench for the delay/commutator at DELAY = 2, 1 and 4 against a frame-level pair model.
// Outputs are sampled on the falling edge, one half cycle after the step edge.
// Only the selected instance sees in_valid; the others sit idle.
module tb_r2mdc_delay_commutator;
    import r2mdc_delay_commutator_pkg::*;

    typedef struct {
        cplx_t      a;
        cplx_t      b;
        logic [7:0] tw;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    r2mdc_delay_commutator_if #(.TW_AW(8)) if2 ();
    r2mdc_delay_commutator_if #(.TW_AW(8)) if1 ();
    r2mdc_delay_commutator_if #(.TW_AW(8)) if4 ();

    r2mdc_delay_commutator #(.DELAY(2), .TW_STRIDE(4), .TW_AW(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    r2mdc_delay_commutator #(.DELAY(1), .TW_STRIDE(1), .TW_AW(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    r2mdc_delay_commutator #(.DELAY(4), .TW_STRIDE(2), .TW_AW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int    cur = 0;
    int    cur_d = 2;
    int    cur_s = 4;
    logic  drv_valid = 1'b0;
    logic  drv_last = 1'b0;
    cplx_t drv_u = '0;
    cplx_t drv_l = '0;

    assign if2.in_valid = drv_valid && (cur == 0);
    assign if1.in_valid = drv_valid && (cur == 1);
    assign if4.in_valid = drv_valid && (cur == 2);
    assign if2.in_last = drv_last;
    assign if1.in_last = drv_last;
    assign if4.in_last = drv_last;
    assign if2.in0_re = drv_u.re;  assign if2.in0_im = drv_u.im;
    assign if2.in1_re = drv_l.re;  assign if2.in1_im = drv_l.im;
    assign if1.in0_re = drv_u.re;  assign if1.in0_im = drv_u.im;
    assign if1.in1_re = drv_l.re;  assign if1.in1_im = drv_l.im;
    assign if4.in0_re = drv_u.re;  assign if4.in0_im = drv_u.im;
    assign if4.in1_re = drv_l.re;  assign if4.in1_im = drv_l.im;

    logic       o_valid, o_last, o_ready, o_err;
    cplx_t      o_a, o_b;
    logic [7:0] o_tw;

    always_comb begin
        o_valid = if2.out_valid; o_last = if2.out_last; o_ready = if2.in_ready; o_err = if2.err_len;
        o_a.re = if2.a_re; o_a.im = if2.a_im; o_b.re = if2.b_re; o_b.im = if2.b_im; o_tw = if2.tw_idx;
        if (cur == 1) begin
            o_valid = if1.out_valid; o_last = if1.out_last; o_ready = if1.in_ready; o_err = if1.err_len;
            o_a.re = if1.a_re; o_a.im = if1.a_im; o_b.re = if1.b_re; o_b.im = if1.b_im; o_tw = if1.tw_idx;
        end else if (cur == 2) begin
            o_valid = if4.out_valid; o_last = if4.out_last; o_ready = if4.in_ready; o_err = if4.err_len;
            o_a.re = if4.a_re; o_a.im = if4.a_im; o_b.re = if4.b_re; o_b.im = if4.b_im; o_tw = if4.tw_idx;
        end
    end

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    cplx_t fu[64];
    cplx_t fl[64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s (D=%0d): observed %0h required %0h", tag, cur_d, obs, expv);
        end
    endtask

    task automatic select_dut(input int idx);
        cur   = idx;
        cur_d = (idx == 0) ? 2 : (idx == 1) ? 1 : 4;
        cur_s = (idx == 0) ? 4 : (idx == 1) ? 1 : 2;
    endtask

    // Frame-level model: each 2D block yields (u_j, u_j+D) for j<D, then (l_j, l_j+D).
    task automatic build_expect(input int n);
        exp_t e;
        for (int b = 0; b < n; b += 2 * cur_d) begin
            for (int j = 0; j < cur_d; j++) begin
                e.a = fu[b+j]; e.b = fu[b+j+cur_d]; e.tw = 8'(j * cur_s); e.last = 1'b0;
                exp_q.push_back(e);
            end
            for (int j = 0; j < cur_d; j++) begin
                e.a = fl[b+j]; e.b = fl[b+j+cur_d]; e.tw = 8'(j * cur_s); e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic observe(input bit exp_valid, input bit check_data);
        exp_t e;
        chk("out_valid", 64'(o_valid), 64'(exp_valid));
        if (!exp_valid) begin
            chk("out_last_idle", 64'(o_last), 64'd0);
        end else if (check_data) begin
            chk("pair_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("a_re", 64'(o_a.re), 64'(e.a.re));
                chk("a_im", 64'(o_a.im), 64'(e.a.im));
                chk("b_re", 64'(o_b.re), 64'(e.b.re));
                chk("b_im", 64'(o_b.im), 64'(e.b.im));
                chk("tw_idx", 64'(o_tw), 64'(e.tw));
                chk("out_last", 64'(o_last), 64'(e.last));
            end
        end
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", 64'(o_ready), 64'd1);
        chk("rst_out_valid", 64'(o_valid), 64'd0);
        chk("rst_out_last", 64'(o_last), 64'd0);
        chk("rst_a", 64'(o_a), 64'd0);
        chk("rst_b", 64'(o_b), 64'd0);
        chk("rst_tw", 64'(o_tw), 64'd0);
        chk("rst_err_len", 64'(o_err), 64'd0);
    endtask

    // Sends fu/fl[0..n-1] as one frame, then runs and checks the drain.
    task automatic send_frame(input int n, input int gap_at, input int gap_len,
                              input bit rnd_gaps, input bit check_data, input bit rst_mid);
        int g;
        int drained;
        if (check_data) build_expect(n);
        for (int i = 0; i < n; i++) begin
            chk("in_ready_in_frame", 64'(o_ready), 64'd1);
            drv_valid = 1'b1; drv_u = fu[i]; drv_l = fl[i]; drv_last = (i == n - 1);
            step_cycle();
            observe(i >= cur_d, check_data);
            drv_valid = 1'b0; drv_last = 1'b0;
            g = (i == gap_at) ? gap_len : (rnd_gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == n - 1) g = 0;
            for (int c = 0; c < g; c++) begin
                drv_u = $urandom; drv_l = $urandom;
                step_cycle();
                observe(1'b0, check_data);
            end
        end
        drained = 0;
        for (int c = 0; c < cur_d + 4; c++) begin
            if (o_ready === 1'b1) break;
            drv_valid = 1'b1; drv_u = $urandom; drv_l = $urandom; drv_last = 1'($urandom);
            step_cycle();
            drained++;
            observe(1'b1, check_data);
            chk("drain_out_last", 64'(o_last), 64'(drained == cur_d));
            if (rst_mid) begin
                drv_valid = 1'b0; drv_last = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_values();
                #2 rst_n = 1'b1;
                @(negedge clk);
                exp_q.delete();
                break;
            end
        end
        drv_valid = 1'b0; drv_last = 1'b0;
        if (!rst_mid) begin
            chk("drain_length", 64'(drained), 64'(cur_d));
            if (check_data) chk("pairs_left", 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic fill_directed_d2();
        for (int i = 0; i < 4; i++) begin
            fu[i].re = 16'(i + 1);  fu[i].im = 16'(-(i + 1));
            fl[i].re = 16'(i + 11); fl[i].im = 16'(200 + i);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            fu[i] = $urandom;
            fl[i] = $urandom;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            select_dut(d);
            #1;
            check_reset_values();
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // DELAY=2 directed frame: (1,3) (2,4) (11,13) (12,14), tw 0,4,0,4.
        select_dut(0);
        fill_directed_d2();
        send_frame(4, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("err_len_clean", 64'(o_err), 64'd0);

        // Same frame with a 3-cycle hole between samples 2 and 3.
        fill_directed_d2();
        send_frame(4, 1, 3, 1'b0, 1'b1, 1'b0);

        // DELAY=1 directed frame with a negative sample, then random frames with gaps.
        select_dut(1);
        fu[0].re = 16'sd5;  fu[0].im = 16'sh8000;
        fu[1].re = 16'sd6;  fu[1].im = 16'sh7FFF;
        fl[0].re = -16'sd7; fl[0].im = -16'sd1;
        fl[1].re = 16'sd8;  fl[1].im = 16'sd0;
        send_frame(2, -1, 0, 1'b0, 1'b1, 1'b0);
        fill_random(6);
        send_frame(6, -1, 0, 1'b1, 1'b1, 1'b0);

        // DELAY=4 back-to-back frames of 8, then a 16-sample frame with gaps.
        select_dut(2);
        fill_random(8);
        send_frame(8, -1, 0, 1'b0, 1'b1, 1'b0);
        fill_random(8);
        send_frame(8, -1, 0, 1'b0, 1'b1, 1'b0);
        fill_random(16);
        send_frame(16, -1, 0, 1'b1, 1'b1, 1'b0);

        // DELAY=2 random frame of 8 with gaps.
        select_dut(0);
        fill_random(8);
        send_frame(8, -1, 0, 1'b1, 1'b1, 1'b0);

        // Length error: in_last on sample 3; sticky across a following good frame.
        fill_random(3);
        send_frame(3, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("err_len_set", 64'(o_err), 64'd1);
        fill_random(4);
        send_frame(4, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("err_len_sticky", 64'(o_err), 64'd1);

        // Reset mid-drain, then the directed frame again.
        fill_random(4);
        send_frame(4, -1, 0, 1'b0, 1'b0, 1'b1);
        chk("err_len_after_rst", 64'(o_err), 64'd0);
        fill_directed_d2();
        send_frame(4, -1, 0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
